ram_dp_scan_ctrl: RTL and testbench

//  Parametrised controller wrapping a dual-port buffer RAM (port A write, port B read).

---
 rtl/ram_dp_scan_ctrl_pkg.sv | 18 +
 rtl/dp_ram_core.sv | 30 +++
 rtl/ram_dp_scan_ctrl.sv | 171 +++++++++++++++++
 tb/tb_ram_dp_scan_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_dp_scan_ctrl_pkg.sv
// Shared types and defaults for the dual-port buffer scan controller.
package ram_dp_scan_ctrl_pkg;

  localparam int unsigned DefDw = 8;
  localparam int unsigned DefAw = 15;

  typedef enum logic {
    WIdle,
    WClear
  } w_state_e;

  typedef enum logic [1:0] {
    RIdle,
    RScan,
    RDrain
  } r_state_e;

endpackage

// File: rtl/dp_ram_core.sv
// Inferred dual-port RAM: port A writes, port B reads with a registered,
// read-first output (a same-address write on the same edge returns old data).
module dp_ram_core #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_en,
  input  logic [AW-1:0] b_addr,
  output logic [DW-1:0] b_data
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DW-1:0] mem [Depth];

  // Port A write.
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_data;
  end

  // Port B registered read; NBA ordering gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (b_en) b_data <= mem[b_addr];
  end

endmodule

// File: rtl/ram_dp_scan_ctrl.sv
// Buffer controller: user writes and hardware clear share RAM port A,
// sequential single-shot or continuous readout scans use port B.
module ram_dp_scan_ctrl
  import ram_dp_scan_ctrl_pkg::*;
#(
  parameter int unsigned   DW        = DefDw,
  parameter int unsigned   AW        = DefAw,
  parameter int unsigned   FRAME_LEN = 2 ** AW,
  parameter logic [DW-1:0] CLR_VAL   = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          clr_start,
  output logic          clr_busy,
  input  logic          rd_start,
  input  logic          rd_cont,
  input  logic          rd_stop,
  output logic          rd_busy,
  output logic          rd_valid,
  output logic [AW-1:0] rd_addr_out,
  output logic [DW-1:0] rd_data,
  output logic          rd_done,
  output logic          wr_collision
);

  // FRAME_LEN = 2**AW truncates to all-ones, so the wrap needs no special case.
  localparam logic [AW-1:0] LastAddr = AW'(FRAME_LEN - 1);
  localparam logic [AW-1:0] MaxAddr  = '1;

  w_state_e      w_state_q, w_state_d;
  r_state_e      r_state_q, r_state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [AW-1:0] iss_addr_q, iss_addr_d;
  logic          cont_q, cont_d;
  logic          stop_pend_q, stop_pend_d;
  logic          ready_en_q;
  logic          rd_valid_q, rd_done_q, wr_collision_q;
  logic [AW-1:0] rd_addr_q;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          issue, scan_last, frame_end, wr_fire;

  // Write side: user writes in idle, clear sweeps every address starting in
  // the clr_start cycle itself so the clear occupies exactly 2**AW cycles.
  always_comb begin
    w_state_d  = w_state_q;
    clr_addr_d = clr_addr_q;
    ram_we     = 1'b0;
    ram_waddr  = wr_addr;
    ram_wdata  = wr_data;
    wr_ready   = 1'b0;
    clr_busy   = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (clr_start) begin
          clr_busy   = 1'b1;
          ram_we     = 1'b1;
          ram_waddr  = '0;
          ram_wdata  = CLR_VAL;
          clr_addr_d = AW'(1);
          w_state_d  = WClear;
        end else begin
          wr_ready = ready_en_q;
          ram_we   = wr_valid & ready_en_q;
        end
      end
      WClear: begin
        clr_busy   = 1'b1;
        ram_we     = 1'b1;
        ram_waddr  = clr_addr_q;
        ram_wdata  = CLR_VAL;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == MaxAddr) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  assign wr_fire = wr_valid & wr_ready;

  // Read side: one issue per cycle in RScan, RDrain covers the RAM latency.
  always_comb begin
    r_state_d   = r_state_q;
    iss_addr_d  = iss_addr_q;
    cont_d      = cont_q;
    stop_pend_d = stop_pend_q;
    issue       = 1'b0;
    scan_last   = 1'b0;
    unique case (r_state_q)
      RIdle: begin
        if (rd_start) begin
          r_state_d   = RScan;
          iss_addr_d  = '0;
          cont_d      = rd_cont;
          stop_pend_d = rd_stop;  // start+stop together: one-word scan
        end
      end
      RScan: begin
        issue      = 1'b1;
        scan_last  = rd_stop | stop_pend_q | ((iss_addr_q == LastAddr) & ~cont_q);
        iss_addr_d = (iss_addr_q == LastAddr) ? '0 : iss_addr_q + 1'b1;
        if (scan_last) begin
          r_state_d   = RDrain;
          stop_pend_d = 1'b0;
        end
      end
      RDrain: r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  assign frame_end = issue & (scan_last | (iss_addr_q == LastAddr));

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q      <= WIdle;
      r_state_q      <= RIdle;
      clr_addr_q     <= '0;
      iss_addr_q     <= '0;
      cont_q         <= 1'b0;
      stop_pend_q    <= 1'b0;
      ready_en_q     <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_done_q      <= 1'b0;
      wr_collision_q <= 1'b0;
      rd_addr_q      <= '0;
    end else begin
      w_state_q      <= w_state_d;
      r_state_q      <= r_state_d;
      clr_addr_q     <= clr_addr_d;
      iss_addr_q     <= iss_addr_d;
      cont_q         <= cont_d;
      stop_pend_q    <= stop_pend_d;
      ready_en_q     <= 1'b1;
      rd_valid_q     <= issue;
      rd_done_q      <= frame_end;
      wr_collision_q <= wr_fire & issue & (wr_addr == iss_addr_q);
      if (issue) rd_addr_q <= iss_addr_q;
    end
  end

  dp_ram_core #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk    (clk),
    .a_we   (ram_we),
    .a_addr (ram_waddr),
    .a_data (ram_wdata),
    .b_en   (issue),
    .b_addr (iss_addr_q),
    .b_data (ram_rdata)
  );

  assign rd_busy      = (r_state_q != RIdle);
  assign rd_valid     = rd_valid_q;
  assign rd_addr_out  = rd_addr_q;
  // RAM output is not reset, so mask it outside valid beats.
  assign rd_data      = rd_valid_q ? ram_rdata : '0;
  assign rd_done      = rd_done_q;
  assign wr_collision = wr_collision_q;

endmodule

// File: tb/tb_ram_dp_scan_ctrl.sv
// Directed bench: DUT a uses FRAME_LEN=16, DUT b FRAME_LEN=5; both share inputs.
module tb_ram_dp_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic wr_valid = 1'b0, clr_start = 1'b0, rd_start = 1'b0, rd_cont = 1'b0, rd_stop = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;

  logic wr_ready_a, clr_busy_a, rd_busy_a, rd_valid_a, rd_done_a, wr_col_a;
  logic wr_ready_b, clr_busy_b, rd_busy_b, rd_valid_b, rd_done_b, wr_col_b;
  logic [3:0] rd_addr_a, rd_addr_b;
  logic [7:0] rd_data_a, rd_data_b;

  always #5 clk = ~clk;

  ram_dp_scan_ctrl #(.DW(8), .AW(4), .FRAME_LEN(16), .CLR_VAL(8'h00)) u_dut_a (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_start(clr_start), .clr_busy(clr_busy_a), .rd_start(rd_start),
    .rd_cont(rd_cont), .rd_stop(rd_stop), .rd_busy(rd_busy_a), .rd_valid(rd_valid_a),
    .rd_addr_out(rd_addr_a), .rd_data(rd_data_a), .rd_done(rd_done_a), .wr_collision(wr_col_a)
  );

  ram_dp_scan_ctrl #(.DW(8), .AW(4), .FRAME_LEN(5), .CLR_VAL(8'h00)) u_dut_b (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_addr(wr_addr),
    .wr_data(wr_data), .clr_start(clr_start), .clr_busy(clr_busy_b), .rd_start(rd_start),
    .rd_cont(rd_cont), .rd_stop(rd_stop), .rd_busy(rd_busy_b), .rd_valid(rd_valid_b),
    .rd_addr_out(rd_addr_b), .rd_data(rd_data_b), .rd_done(rd_done_b), .wr_collision(wr_col_b)
  );

  // Scan observations come from the selected DUT.
  logic sel_b = 1'b0;
  logic o_valid, o_busy, o_done, o_col;
  logic [3:0] o_addr;
  logic [7:0] o_data;
  assign o_valid = sel_b ? rd_valid_b : rd_valid_a;
  assign o_busy  = sel_b ? rd_busy_b  : rd_busy_a;
  assign o_done  = sel_b ? rd_done_b  : rd_done_a;
  assign o_col   = sel_b ? wr_col_b   : wr_col_a;
  assign o_addr  = sel_b ? rd_addr_b  : rd_addr_a;
  assign o_data  = sel_b ? rd_data_b  : rd_data_a;

  logic [17:0] outs_a, outs_b;
  assign outs_a = {wr_ready_a, clr_busy_a, rd_busy_a, rd_valid_a, rd_addr_a, rd_data_a,
                   rd_done_a, wr_col_a};
  assign outs_b = {wr_ready_b, clr_busy_b, rd_busy_b, rd_valid_b, rd_addr_b, rd_data_b,
                   rd_done_b, wr_col_b};

  int errors = 0;
  int checks = 0;

  logic [3:0] b_addr [64];
  logic [7:0] b_data [64];
  logic       b_done [64];
  logic       b_col  [64];
  int nb, gaps, done_tot, col_tot, j_last, j_end;
  int busy_cnt, low_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one scan; cycle j counts negedges from the rd_start drive (j=0).
  // rd_stop / a write are driven at the chosen cycles.
  task automatic scan(input bit cont, input int stop_cyc, input int wr_cyc,
                      input logic [3:0] wa, input logic [7:0] wd);
    nb = 0; gaps = 0; done_tot = 0; col_tot = 0; j_last = -1; j_end = -1;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      rd_start = 1'b0; rd_stop = 1'b0; wr_valid = 1'b0;
      if (j > 0) begin
        if (o_valid) begin
          if (nb < 64) begin
            b_addr[nb] = o_addr; b_data[nb] = o_data; b_done[nb] = o_done; b_col[nb] = o_col;
          end
          nb++;
          j_last = j;
        end else if (o_busy && nb > 0) begin
          gaps++;
        end
        if (o_done) done_tot++;
        if (o_col) col_tot++;
        if (!o_busy) begin
          j_end = j;
          break;
        end
      end
      rd_start = (j == 0);
      rd_cont  = cont;
      rd_stop  = (j == stop_cyc);
      wr_valid = (j == wr_cyc);
      wr_addr  = wa;
      wr_data  = wd;
    end
    check("scan_terminates", (j_end > 0), 1);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outs_a", outs_a, 0);
    check("reset_outs_b", outs_b, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", wr_ready_a, 1);
    check("clr_busy_idle", clr_busy_a, 0);

    // Test 1: fill with k+0x10, single scan.
    for (int k = 0; k < 16; k++) begin
      wr_valid = 1'b1; wr_addr = 4'(k); wr_data = 8'(k + 8'h10);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    scan(1'b0, -1, -1, 4'h0, 8'h00);
    check("t1_beats", nb, 16);
    check("t1_gaps", gaps, 0);
    for (int k = 0; k < 16; k++) begin
      check("t1_addr", b_addr[k], k);
      check("t1_data", b_data[k], k + 8'h10);
    end
    check("t1_done_last", b_done[15], 1);
    check("t1_done_count", done_tot, 1);
    check("t1_busy_drop", j_end, j_last + 1);

    // Test 2: clear, with a simultaneous write and a re-trigger during clear.
    @(negedge clk);
    clr_start = 1'b1; wr_valid = 1'b1; wr_addr = 4'h7; wr_data = 8'h55;
    #1;
    check("t2_ready_same_cycle", wr_ready_a, 0);
    check("t2_busy_same_cycle", clr_busy_a, 1);
    busy_cnt = 1; low_cnt = 1;
    for (int k = 1; k < 40; k++) begin
      @(negedge clk);
      clr_start = (k == 5); wr_valid = 1'b0;
      #1;
      if (!clr_busy_a) break;
      busy_cnt++;
      if (!wr_ready_a) low_cnt++;
    end
    clr_start = 1'b0;
    check("t2_busy_cycles", busy_cnt, 16);
    check("t2_ready_low_cycles", low_cnt, 16);
    check("t2_ready_back", wr_ready_a, 1);
    scan(1'b0, -1, -1, 4'h0, 8'h00);
    check("t2_beats", nb, 16);
    for (int k = 0; k < 16; k++) check("t2_data_cleared", b_data[k], 8'h00);

    // Test 3: continuous, stop at issue of addr 5 in frame 2.
    scan(1'b1, 22, -1, 4'h0, 8'h00);
    check("t3_beats", nb, 22);
    check("t3_gaps", gaps, 0);
    for (int k = 0; k < 22; k++) check("t3_addr", b_addr[k], k % 16);
    check("t3_done_count", done_tot, 2);
    check("t3_done_frame1", b_done[15], 1);
    check("t3_done_stop", b_done[21], 1);
    check("t3_busy_drop", j_end, j_last + 1);

    // Test 4: write AA to addr 3 while addr 3 is issued.
    scan(1'b1, 20, 4, 4'h3, 8'hAA);
    check("t4_beats", nb, 20);
    check("t4_old_data", b_data[3], 8'h00);
    check("t4_collision", b_col[3], 1);
    check("t4_collision_count", col_tot, 1);
    check("t4_next_addr", b_addr[19], 4'h3);
    check("t4_new_data", b_data[19], 8'hAA);
    check("t4_done_count", done_tot, 2);

    // Test 5: FRAME_LEN=5 instance.
    rd_cont = 1'b0;
    repeat (20) @(negedge clk);
    sel_b = 1'b1;
    scan(1'b0, -1, -1, 4'h0, 8'h00);
    check("t5_beats", nb, 5);
    for (int k = 0; k < 5; k++) check("t5_addr", b_addr[k], k);
    check("t5_done_last", b_done[4], 1);
    check("t5_done_count", done_tot, 1);
    scan(1'b0, 0, -1, 4'h0, 8'h00);
    check("t5_one_beat", nb, 1);
    check("t5_one_addr", b_addr[0], 4'h0);
    check("t5_one_done", b_done[0], 1);
    sel_b = 1'b0;
    repeat (20) @(negedge clk);

    // Test 6: reset mid-scan and mid-clear.
    clr_start = 1'b1; rd_start = 1'b1; rd_cont = 1'b1;
    @(negedge clk);
    clr_start = 1'b0; rd_start = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_scan_running", rd_valid_a, 1);
    #2 rst = 1'b1;
    #1 check("t6_async_zero_a", outs_a, 0);
    check("t6_async_zero_b", outs_b, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t6_held_zero", outs_a, 0);
    end
    rst = 1'b0; rd_cont = 1'b0;
    @(negedge clk);
    check("t6_ready", wr_ready_a, 1);
    check("t6_clr_idle", clr_busy_a, 0);
    check("t6_rd_idle", rd_busy_a, 0);
    scan(1'b0, -1, -1, 4'h0, 8'h00);
    check("t6_beats", nb, 16);
    check("t6_first_addr", b_addr[0], 4'h0);
    check("t6_done_last", b_done[15], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
